// File: rtl/sal_resp_encoder.sv
// AXI read/write response encoder: queues read contexts, read beats and write completions, then drives R and B.
// Optional SAL_RESP_ERR_CHK_EN builds a sticky err flag for overflow / orphan-beat / write-done-full events.

module sal_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage carries no reset; consumers gate the head with their valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];
endmodule

module sal_resp_encoder #(
  parameter int ID_W      = 4,
  parameter int DATA_W    = 128,
  parameter int CTX_DEPTH = 4,
  parameter int DF_DEPTH  = 16,
  parameter int BF_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_ctx_valid,
  input  logic [ID_W-1:0]   rd_ctx_id,
  input  logic [7:0]        rd_ctx_len,
  output logic              rd_ctx_ready,
  input  logic              rdata_valid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              wr_done_valid,
  input  logic [ID_W-1:0]   wr_done_id,
  output logic              wr_done_ready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              err
);
  localparam int CTX_CW = $clog2(CTX_DEPTH) + 1;
  localparam int DF_CW  = $clog2(DF_DEPTH) + 1;
  localparam int BF_CW  = $clog2(BF_DEPTH) + 1;

  // Handshakes: a transfer happens on any rising edge where valid && ready;
  // producers hold payload stable while valid && !ready.
  typedef enum logic {R_IDLE = 1'b0, R_BURST = 1'b1} r_state_t;

  r_state_t r_state, r_next;
  logic [7:0] beat_cnt;

  logic [CTX_CW-1:0]    ctx_count;
  logic [DF_CW-1:0]     df_count;
  logic [BF_CW-1:0]     bf_count;
  logic                 ctx_full, ctx_empty, df_full, df_empty, bf_full, bf_empty;
  logic                 ctx_push, ctx_pop, df_push, df_pop, bf_push, bf_pop;
  logic [ID_W+7:0]      ctx_head;
  logic [ID_W-1:0]      head_id;
  logic [7:0]           head_len;
  logic [DATA_W-1:0]    df_head;
  logic [ID_W-1:0]      bf_head;
  logic                 r_hs;

  assign ctx_full  = (ctx_count == CTX_CW'(CTX_DEPTH));
  assign ctx_empty = (ctx_count == '0);
  assign df_full   = (df_count == DF_CW'(DF_DEPTH));
  assign df_empty  = (df_count == '0);
  assign bf_full   = (bf_count == BF_CW'(BF_DEPTH));
  assign bf_empty  = (bf_count == '0);

  assign {head_id, head_len} = ctx_head;

  assign rd_ctx_ready  = !ctx_full;
  assign wr_done_ready = !bf_full;

  assign rvalid  = (r_state == R_BURST) && !df_empty;
  assign rlast   = (r_state == R_BURST) && (beat_cnt == head_len);
  assign rid     = (r_state == R_BURST) ? head_id : '0;
  assign rdata_o = rvalid ? df_head : '0;
  assign rresp   = 2'b00;

  assign r_hs     = rvalid && rready;
  assign ctx_push = rd_ctx_valid && !ctx_full;
  assign ctx_pop  = r_hs && rlast;
  assign df_pop   = r_hs;
  // A full data FIFO still accepts a beat when the head leaves on the same edge.
  assign df_push  = rdata_valid && (!df_full || df_pop);

  assign bvalid  = !bf_empty;
  assign bid     = bvalid ? bf_head : '0;
  assign bresp   = 2'b00;
  assign bf_push = wr_done_valid && !bf_full;
  assign bf_pop  = bvalid && bready;

  sal_resp_fifo #(.W(ID_W + 8), .DEPTH(CTX_DEPTH)) u_ctx_fifo (
    .clk(clk), .rst(rst), .push(ctx_push), .pop(ctx_pop),
    .din({rd_ctx_id, rd_ctx_len}), .dout(ctx_head), .count(ctx_count)
  );

  sal_resp_fifo #(.W(DATA_W), .DEPTH(DF_DEPTH)) u_data_fifo (
    .clk(clk), .rst(rst), .push(df_push), .pop(df_pop),
    .din(rdata), .dout(df_head), .count(df_count)
  );

  sal_resp_fifo #(.W(ID_W), .DEPTH(BF_DEPTH)) u_bdone_fifo (
    .clk(clk), .rst(rst), .push(bf_push), .pop(bf_pop),
    .din(wr_done_id), .dout(bf_head), .count(bf_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= R_IDLE;
      beat_cnt <= '0;
    end else begin
      r_state <= r_next;
      if (ctx_pop)   beat_cnt <= '0;
      else if (r_hs) beat_cnt <= beat_cnt + 8'd1;
    end
  end

  // Stay in R_BURST when another context will be waiting after the last beat.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (!ctx_empty) r_next = R_BURST;
      R_BURST: if (ctx_pop && (ctx_count == CTX_CW'(1)) && !ctx_push) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

`ifdef SAL_RESP_ERR_CHK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((rdata_valid && df_full && !df_pop) ||
                 (rdata_valid && ctx_empty) ||
                 (wr_done_valid && bf_full)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: doc/sal_resp_encoder.md
SAL_RESP_ENCODER -- requirements
Module: sal_resp_encoder

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ID_W, 4, AXI ID width
- DATA_W, 128, read data beat width
- CTX_DEPTH, 4, pending-read context FIFO entries (power of 2)
- DF_DEPTH, 16, read data FIFO entries (power of 2)
- BF_DEPTH, 2, write-done FIFO entries (power of 2)

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- rd_ctx_valid  in  1  read context push (one per read burst accepted by bank controller)
- rd_ctx_id  in  ID_W  burst AXI ID
- rd_ctx_len  in  8  burst length minus one
- rd_ctx_ready  out  1  context FIFO not full
- rdata_valid  in  1  DRAM read beat; no backpressure
- rdata  in  DATA_W  beat data
- wr_done_valid  in  1  write burst completed
- wr_done_id  in  ID_W  completed write ID
- wr_done_ready  out  1  write-done FIFO not full
- rid, rdata_o, rresp, rlast, rvalid  out  ID_W, DATA_W, 2, 1, 1  AXI R channel
- rready  in  1  AXI R ready
- bid, bresp, bvalid  out  ID_W, 2, 1  AXI B channel
- bready  in  1  AXI B ready
- err  out  1  sticky protocol-error flag

Function
REQ-003 Context, data and write-done storage SHALL each be synchronous FIFOs; push SHALL occur on valid&&ready (data: on rdata_valid when not full, or when full with a same-cycle pop).
REQ-004 rd_ctx_ready SHALL equal !ctx_full; wr_done_ready SHALL equal !bf_full; there SHALL be no full-FIFO bypass on these inputs.
REQ-005 R FSM SHALL have states R_IDLE and R_BURST, with beat counter beat_cnt (8 bits).
REQ-006 Transitions: R_IDLE -> R_BURST when the context FIFO is non-empty (beat_cnt=0); R_BURST -> R_IDLE on the last-beat handshake when the context FIFO holds no further entry after the pop; otherwise stay in R_BURST with the next context.
REQ-007 In R_BURST, rvalid SHALL equal data-FIFO non-empty; rid SHALL be the head context ID; rdata_o SHALL be the data head; rresp SHALL be 2'b00; rlast SHALL be (beat_cnt == head len).
REQ-008 On rvalid&&rready: pop data; if rlast, pop context and clear beat_cnt, else increment beat_cnt.
REQ-009 rvalid SHALL be 0 in R_IDLE; R outputs SHALL hold stable while rvalid&&!rready.
REQ-010 First-beat latency: a beat arriving with context present SHALL appear on rvalid the cycle after the push (registered FIFO, no combinational path from rdata_valid to rvalid).
REQ-011 B channel: bvalid SHALL equal write-done FIFO non-empty; bid SHALL be the head ID; bresp SHALL be 2'b00; pop on bvalid&&bready.
REQ-012 B and R channels SHALL be independent; simultaneous push and pop on any FIFO SHALL keep the occupancy unchanged.
REQ-013 rdata_valid while the data FIFO is full and no pop occurs in the same cycle SHALL drop the beat (overflow).

Reset
REQ-014 While rst=1, all FIFOs SHALL be empty, FSM=R_IDLE, beat_cnt=0, rvalid=bvalid=0, rlast=0, err=0, rd_ctx_ready=wr_done_ready=1, and rid/bid/rresp/bresp/rdata_o=0.
REQ-015 Reset asserted mid-burst SHALL discard all pending contexts, beats and write completions without emitting a handshake.

Configuration
REQ-016 Macro SAL_RESP_ERR_CHK_EN: when defined, err SHALL set sticky on a data overflow, on rdata_valid while the context FIFO is empty, or on wr_done_valid while the write-done FIFO is full; it clears only on rst. When undefined, err SHALL be tied 0 and no check logic SHALL be built.

Verification
REQ-017 Push context (id=3, len=3), 4 beats 0xA..0xD, rready=1 -> 4 R beats with rid=3, data A..D, rlast only on beat 4, FSM back to R_IDLE.
REQ-018 Two contexts (id=1, len=0) and (id=2, len=1), 3 beats, rready toggling 1/0 -> beats stay stable during stall, rlast on beats 1 and 3, rid 1,2,2.
REQ-019 rready=0, 17 beats into DF_DEPTH=16 -> 16 retained, 17th dropped; err=1 with SAL_RESP_ERR_CHK_EN, err=0 without it.
REQ-020 wr_done ids 5,6,7 back-to-back, bready=0 -> wr_done_ready=0 after 2 entries; releasing bready -> bid 5,6 then 7 accepted, bresp=0.
REQ-021 Assert rst mid-burst (after beat 2 of len=3) -> rvalid=0 next cycle, FIFOs empty; a new context plus 1 beat (len=0) after reset -> single beat with rlast=1.
